// File: rtl/argmax_accumulator.sv
// -----------------------------------------------------------------------------
// argmax_accumulator
//
// Accumulates per-group (maximum, position) results coming out of a
// max_finder_set over the G beats of one sample. It produces the global
// maximum and its global index, compares that index with the sample label,
// and keeps saturating counters of correct and completed samples.
//
// Parameters:
//   width : activation bit width
//   z     : entries per group (power of two, >= 2)
//   G     : groups (beats) per sample (>= 1)
//   CW    : width of the correct/sample counters
//
// Ports:
//   clk         in   clock, rising edge
//   reset_n     in   asynchronous active-low reset, clears every register
//   clr         in   synchronous clear of counters and any partial sample
//   in_valid    in   a group result is present this cycle
//   grp_max     in   group maximum
//   grp_pos     in   position of the maximum inside the group
//   label       in   ideal class index, used on the final beat only
//   out_valid   out  one-cycle pulse, sample result valid
//   max_val     out  global maximum of the completed sample
//   max_idx     out  global index of max_val
//   correct     out  max_idx == label for the completed sample
//   num_correct out  saturating count of correct samples
//   num_samples out  saturating count of completed samples
// -----------------------------------------------------------------------------
module argmax_accumulator #(
  parameter int width = 4,
  parameter int z     = 32,
  parameter int G     = 4,
  parameter int CW    = 16,
  localparam int IW   = $clog2(z * G),
  localparam int PW   = $clog2(z)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             in_valid,
  input  logic [width-1:0] grp_max,
  input  logic [PW-1:0]    grp_pos,
  input  logic [IW-1:0]    label,
  output logic             out_valid,
  output logic [width-1:0] max_val,
  output logic [IW-1:0]    max_idx,
  output logic             correct,
  output logic [CW-1:0]    num_correct,
  output logic [CW-1:0]    num_samples
);

  // Group counter width; a single-group sample still needs a 1-bit counter.
  localparam int GW = (G > 1) ? $clog2(G) : 1;

  logic [GW-1:0]    gcnt_r;
  logic [width-1:0] run_max_r;
  logic [IW-1:0]    run_idx_r;

  logic             first_beat_s;
  logic             last_beat_s;
  logic [IW-1:0]    beat_idx_s;
  logic [width-1:0] cand_max_s;
  logic [IW-1:0]    cand_idx_s;
  logic             cand_hit_s;

  // Beat classification and winner selection including the current beat.
  always_comb begin
    first_beat_s = (gcnt_r == GW'(0));
    last_beat_s  = (gcnt_r == GW'(G - 1));
    // z is a power of two, so gcnt*z + pos is a plain concatenation. For
    // G == 1 the single gcnt bit is always zero and is truncated away.
    beat_idx_s   = IW'({gcnt_r, grp_pos});
    // Strict greater-than keeps the earlier (lower) index on ties.
    if (first_beat_s || (grp_max > run_max_r)) begin
      cand_max_s = grp_max;
      cand_idx_s = beat_idx_s;
    end else begin
      cand_max_s = run_max_r;
      cand_idx_s = run_idx_r;
    end
    cand_hit_s = (cand_idx_s == label);
  end

  // Sample accumulation, result registers and saturating counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gcnt_r      <= GW'(0);
      run_max_r   <= '0;
      run_idx_r   <= '0;
      out_valid   <= 1'b0;
      max_val     <= '0;
      max_idx     <= '0;
      correct     <= 1'b0;
      num_correct <= '0;
      num_samples <= '0;
    end else if (clr) begin
      // Any beat in this cycle is dropped; result registers hold.
      gcnt_r      <= GW'(0);
      out_valid   <= 1'b0;
      num_correct <= '0;
      num_samples <= '0;
    end else begin
      out_valid <= 1'b0;
      if (in_valid) begin
        run_max_r <= cand_max_s;
        run_idx_r <= cand_idx_s;
        if (last_beat_s) begin
          gcnt_r    <= GW'(0);
          out_valid <= 1'b1;
          max_val   <= cand_max_s;
          max_idx   <= cand_idx_s;
          correct   <= cand_hit_s;
          if (num_samples != {CW{1'b1}}) begin
            num_samples <= num_samples + CW'(1);
          end else begin
            num_samples <= num_samples;
          end
          if (cand_hit_s && (num_correct != {CW{1'b1}})) begin
            num_correct <= num_correct + CW'(1);
          end else begin
            num_correct <= num_correct;
          end
        end else begin
          gcnt_r <= gcnt_r + GW'(1);
        end
      end else begin
        gcnt_r <= gcnt_r;
      end
    end
  end

endmodule
